rvfi_trace_serializer: RTL
==========================

# rvfi_trace_serializer

Transmit side of the RVFI trace path: captures one retirement record per `rvfi_valid` pulse from the RS5 core, buffers it in a small FIFO, and emits it as a byte stream. Each frame uses the exact packed little-endian layout of the host-side `rvfi_trace_t` record, with XLEN = 32. The block sits between the core's RVFI outputs and a byte-wide link such as a UART TX or a DPI byte sink, so the host monitor can rebuild trace structs.

## Interface
- FIFO_DEPTH, 4, number of buffered records; power of two, ≥ 2
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rvfi_valid  in  1  one retirement record present this cycle
- rvfi_order  in  64  retirement index
- rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  in  32 each  RVFI fields
- rvfi_trap, rvfi_halt, rvfi_intr  in  1 each  RVFI flags
- rvfi_mode, rvfi_ixl  in  2 each  privilege mode, XLEN code
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  in  5 each  register indices
- rvfi_mem_rmask, rvfi_mem_wmask  in  4 each  byte masks
- tx_data  out  8  current frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte
- overflow  out  1  sticky: at least one record dropped
- drop_count  out  8  dropped records, saturates at 0xFF

## Operation
- Push: on a `rvfi_valid` cycle, all fields are written to the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, the record is dropped: `overflow` is set and `drop_count` is incremented.
  - Pop occurs on the handshake of the last frame byte. A push in the same cycle as a pop is always accepted.
- Frame layout (byte offset: content). Multi-byte fields are little-endian. Narrow fields are zero-extended to one byte.
  - 0: header 0xA5
  - 1–8: order
  - 9–12: insn
  - 13–20: trap, halt, intr, mode, ixl, rs1_addr, rs2_addr, rd_addr (one byte each)
  - 21–44: rs1_rdata, rs2_rdata, rd_wdata, pc_rdata, pc_wdata, mem_addr (four bytes each)
  - 45: rmask
  - 46: wmask
  - 47–50: mem_rdata
  - 51–54: mem_wdata
  - 55: valid, always 0x01
  - Base frame length is 56 bytes.
- FSM states:
  - IDLE: `tx_valid` = 0. Go to SEND when the FIFO is non-empty.
  - SEND: byte index `idx` runs 0..55 and `tx_data` = byte[`idx`] of the FIFO head. On a handshake, `idx` is incremented. On the handshake at `idx` = 55, go to CRC (if configured), otherwise pop and go to SEND (FIFO non-empty after pop) or IDLE.
  - CRC: sends one CRC byte. On its handshake, pop, then go to SEND or IDLE by the same rule.
- The head record is never modified while it is being serialized.

## Timing
- Reset values: `tx_valid` = 0, `tx_data` = 0x00, `overflow` = 0, `drop_count` = 0, FIFO empty, state IDLE, `idx` = 0.
- Latency: a record pushed at edge N into an empty FIFO gives `tx_valid` = 1 with header 0xA5 from cycle N+1.
- Handshake: a byte transfers on any cycle where `tx_valid` and `tx_ready` are both 1.
  - While `tx_valid` = 1 and `tx_ready` = 0, `tx_data` holds stable.
  - `tx_valid` never drops mid-frame.
- Back-to-back frames: the next header follows the last byte on the very next cycle, with no bubble. With `tx_ready` held at 1, throughput is one byte per cycle.
- `tx_data` is driven from registers (no combinational path from RVFI inputs); the byte mux selects from the registered FIFO head.
- Reset mid-frame: the partial frame is abandoned, the FIFO is flushed, and all outputs return to their reset values on the next cycle.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH.
  - full = MSBs differ and LSBs are equal.

## Configuration
- RVFI_TRACE_CRC_EN defined:
  - A 57th byte is appended: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over bytes 0–55.
  - The CRC accumulates as each byte is handshaked.
- Undefined: 56-byte frames, no CRC state or logic.

## Test plan
- Single record, `tx_ready` = 1: push order=0x1, insn=0x00000013, pc_rdata=0x80000000, valid → 56 consecutive bytes; byte0=0xA5, byte1=0x01, bytes 9–12=13 00 00 00, bytes 33–36=00 00 00 80, byte55=0x01.
- Backpressure: toggle `tx_ready` pseudo-randomly → no byte duplicated or lost; `tx_data` stable while stalled; frame content identical to the unstalled case.
- Overflow: FIFO_DEPTH=4, `tx_ready` = 0, push 6 records → 4 buffered, `overflow` = 1, `drop_count` = 2; after release, 4 frames with orders 0–3.
- Full-with-pop: FIFO full, push in the same cycle as the last-byte handshake → record accepted, `drop_count` unchanged.
- Reset at byte 20 of a frame → `tx_valid` = 0 the next cycle; the next pushed record starts with 0xA5 and order intact.
- With RVFI_TRACE_CRC_EN: frame of all-zero fields except valid → 57 bytes; last byte equals the reference CRC-8 of bytes 0–55.

Source files
------------

// File: rtl/rvfi_trace_serializer.sv
// RVFI retirement record capture, FIFO buffering and little-endian byte-stream framing.
// Optional trailing CRC-8 byte enabled by defining RVFI_TRACE_CRC_EN.
module rvfi_trace_serializer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [1:0]  rvfi_mode,
  input  logic [1:0]  rvfi_ixl,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned FW       = 448;
  localparam logic [5:0]  LAST_IDX = 6'd55;

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef RVFI_TRACE_CRC_EN
    , CRC
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic          overflow_q;
  logic [7:0]    drop_count_q;
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [FW-1:0] rec_frame;
  logic [7:0]    head_byte;
  logic          empty, full, pop, push_ok, drop;

  // Frame bytes are stored pre-packed, byte k at bits [8k+7:8k]
  assign rec_frame = {
    8'h01,
    rvfi_mem_wdata, rvfi_mem_rdata,
    {4'b0, rvfi_mem_wmask}, {4'b0, rvfi_mem_rmask},
    rvfi_mem_addr, rvfi_pc_wdata, rvfi_pc_rdata,
    rvfi_rd_wdata, rvfi_rs2_rdata, rvfi_rs1_rdata,
    {3'b0, rvfi_rd_addr}, {3'b0, rvfi_rs2_addr}, {3'b0, rvfi_rs1_addr},
    {6'b0, rvfi_ixl}, {6'b0, rvfi_mode},
    {7'b0, rvfi_intr}, {7'b0, rvfi_halt}, {7'b0, rvfi_trap},
    rvfi_insn, rvfi_order,
    8'hA5
  };

  assign empty     = (rd_ptr_q == wr_ptr_q);
  assign full      = (rd_ptr_q[PW] != wr_ptr_q[PW]) && (rd_ptr_q[PW-1:0] == wr_ptr_q[PW-1:0]);
  assign head_byte = mem_q[rd_ptr_q[PW-1:0]][{idx_q, 3'b000} +: 8];

`ifdef RVFI_TRACE_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tx_valid = 1'b0;
    tx_data  = '0;
    pop      = 1'b0;
`ifdef RVFI_TRACE_CRC_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) state_d = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = head_byte;
        if (tx_ready) begin
`ifdef RVFI_TRACE_CRC_EN
          crc_d = crc8_step(crc_q, head_byte);
`endif
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef RVFI_TRACE_CRC_EN
            state_d = CRC;
`else
            pop = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
`ifdef RVFI_TRACE_CRC_EN
      CRC: begin
        tx_valid = 1'b1;
        tx_data  = crc_q;
        if (tx_ready) begin
          pop   = 1'b1;
          crc_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A pop frees the head slot this cycle, so a simultaneous push always fits
    push_ok  = rvfi_valid && (!full || pop);
    drop     = rvfi_valid && !push_ok;
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
    wr_ptr_d = wr_ptr_q + (PW+1)'(push_ok);
    if (pop) state_d = (rd_ptr_d != wr_ptr_d) ? SEND : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
`ifdef RVFI_TRACE_CRC_EN
      crc_q        <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
`ifdef RVFI_TRACE_CRC_EN
      crc_q <= crc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= rec_frame;
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
